deserializer: RTL and testbench

Serial-to-parallel converter: the receiving end of the team's serial data link. It samples a 1-bit stream qualified by a valid strobe, MSB first. It assembles `DATA_W`-bit words and presents each completed word with a one-cycle valid pulse. It sits downstream of the serializer on the same link and uses the same bit order and valid-strobe semantics.

---
 rtl/deserializer.sv | 83 ++++++++
 tb/tb_deserializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: MSB-first bits in, DATA_W-bit words out.
// Optional macro DESERIALIZER_LAST_EN adds early frame termination.
module deserializer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
`ifdef DESERIALIZER_LAST_EN
    input  logic              data_last_i,
    output logic [CNT_W-1:0]  deser_mod_o,
`endif
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              val_q, val_d;
    logic [CNT_W-1:0]  mod_q, mod_d;
    logic [DATA_W-1:0] word;
    logic              full;
    logic              done;

    // Place the incoming bit, detect word end, compute next state.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        word    = shreg_q;
        full    = (cnt_q == CNT_W'(DATA_W - 1));
        done    = full;
`ifdef DESERIALIZER_LAST_EN
        done    = full | data_last_i;
`endif
        for (int i = 0; i < DATA_W; i++) begin
            if (CNT_W'(DATA_W - 1 - i) == cnt_q) begin
                word[i] = data_i;
            end
        end
        if (data_val_i) begin
            if (done) begin
                data_d  = word;
                val_d   = 1'b1;
                cnt_d   = '0;
                shreg_d = '0;
                mod_d   = full ? '0 : cnt_q + CNT_W'(1);
            end else begin
                shreg_d = word;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
            mod_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            val_q   <= val_d;
            mod_q   <= mod_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_val_o = val_q;
`ifdef DESERIALIZER_LAST_EN
    assign deser_mod_o      = mod_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer against a queue-based frame model.
// Optional macro DESERIALIZER_LAST_EN enables the short-frame checks.
module tb_deserializer;

    localparam int DW = 16;
    localparam int CW = $clog2(DW);

    logic          clk = 1'b0;
    logic          srst = 1'b0;
    logic          din = 1'b0;
    logic          dval = 1'b0;
    logic          dlast = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_val;
    logic [CW-1:0] dmod;

    int errors = 0;
    int checks = 0;

    deserializer #(.DATA_W(DW)) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .data_i           (din),
        .data_val_i       (dval),
`ifdef DESERIALIZER_LAST_EN
        .data_last_i      (dlast),
        .deser_mod_o      (dmod),
`endif
        .deser_data_o     (dout),
        .deser_data_val_o (dout_val)
    );

`ifndef DESERIALIZER_LAST_EN
    assign dmod = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: collect accepted bits in a queue, emit on frame end.
    bit            mq[$];
    logic [DW-1:0] exp_data = '0;
    logic          exp_val = 1'b0;
    logic [CW-1:0] exp_mod = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        logic [DW-1:0] w;
        bit            lst;
        cyc++;
        exp_val = 1'b0;
        lst = 1'b0;
`ifdef DESERIALIZER_LAST_EN
        lst = dlast;
`endif
        if (!srst) begin
            mq.delete();
            exp_data = '0;
            exp_mod  = '0;
        end else if (dval) begin
            mq.push_back(din);
            if (mq.size() == DW || lst) begin
                w = '0;
                for (int i = 0; i < mq.size(); i++) w[DW-1-i] = mq[i];
                exp_data = w;
                exp_mod  = CW'(mq.size() % DW);
                exp_val  = 1'b1;
                mq.delete();
            end
        end
    end

    // Per-cycle comparison and pulse bookkeeping.
    int            pulses = 0;
    int            pcyc[$];
    logic [DW-1:0] last_word = '0;
    logic [CW-1:0] last_mod = '0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("val", 32'(dout_val), 32'(exp_val));
            chk("data", 32'(dout), 32'(exp_data));
`ifdef DESERIALIZER_LAST_EN
            chk("mod", 32'(dmod), 32'(exp_mod));
`endif
            if (dout_val === 1'b1) begin
                pulses++;
                pcyc.push_back(cyc);
                last_word = dout;
                last_mod  = dmod;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input bit l, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        for (int k = 0; k < g; k++) begin
            dval  = 1'b0;
            din   = 1'($urandom);
            dlast = 1'($urandom);
            tick();
        end
        dval  = 1'b1;
        din   = b;
        dlast = l;
        tick();
        dval  = 1'b0;
        dlast = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gmax);
        for (int i = DW - 1; i >= 0; i--) send_bit(w[i], 1'b0, gmax);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int p0;
    int bitcyc;
    logic [4:0] sh;

    initial begin
        // Reset with random inputs for 3 cycles.
        srst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din   = 1'($urandom);
            dval  = 1'($urandom);
            dlast = 1'($urandom);
            tick();
            chk("rst_data", 32'(dout), 32'h0);
            chk("rst_val", 32'(dout_val), 32'h0);
        end
        dval  = 1'b0;
        dlast = 1'b0;
        srst  = 1'b1;
        tick();
        chk("post_rst_data", 32'(dout), 32'h0);
        chk("post_rst_val", 32'(dout_val), 32'h0);

        // Single word, no gaps.
        p0 = pulses;
        send_word(16'hA5C3, 0);
        bitcyc = cyc;
        chk("single_now", 32'(dout_val), 32'h1);
        idle(4);
        chk("single_cnt", 32'(pulses - p0), 32'd1);
        chk("single_word", 32'(last_word), 32'hA5C3);
        chk("single_lat", 32'(pcyc[$]), 32'(bitcyc));
        chk("single_hold", 32'(dout), 32'hA5C3);

        // Same word with random gaps.
        p0 = pulses;
        send_word(16'hA5C3, 5);
        idle(3);
        chk("gap_cnt", 32'(pulses - p0), 32'd1);
        chk("gap_word", 32'(last_word), 32'hA5C3);

        // Back-to-back words.
        p0 = pulses;
        send_word(16'hFFFF, 0);
        chk("b2b_first", 32'(dout), 32'hFFFF);
        send_word(16'h0001, 0);
        idle(2);
        chk("b2b_cnt", 32'(pulses - p0), 32'd2);
        chk("b2b_space", 32'(pcyc[$] - pcyc[$-1]), 32'd16);
        chk("b2b_word", 32'(last_word), 32'h0001);

        // Reset in the middle of a word.
        p0 = pulses;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0, 0);
        srst = 1'b0;
        tick();
        srst = 1'b1;
        send_word(16'h1234, 0);
        idle(2);
        chk("midrst_cnt", 32'(pulses - p0), 32'd1);
        chk("midrst_word", 32'(last_word), 32'h1234);

`ifdef DESERIALIZER_LAST_EN
        // Short frame followed by a full word.
        p0 = pulses;
        sh = 5'b10110;
        for (int i = 4; i >= 0; i--) send_bit(sh[i], i == 0, 0);
        idle(1);
        chk("short_word", 32'(last_word), 32'hB000);
        chk("short_mod", 32'(last_mod), 32'd5);
        send_word(16'h8001, 0);
        idle(1);
        chk("after_word", 32'(last_word), 32'h8001);
        chk("after_mod", 32'(last_mod), 32'd0);
        chk("short_cnt", 32'(pulses - p0), 32'd2);

        // One-bit frames back to back.
        p0 = pulses;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b1, 0);
        idle(1);
        chk("onebit_cnt", 32'(pulses - p0), 32'd2);
        chk("onebit_space", 32'(pcyc[$] - pcyc[$-1]), 32'd1);
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int n = 0; n < 40; n++) begin
            bit l;
            l = 1'b0;
`ifdef DESERIALIZER_LAST_EN
            l = ($urandom_range(15, 0) == 0);
`endif
            send_bit(1'($urandom), l, 3);
            if ($urandom_range(99, 0) < 2) begin
                srst = 1'b0;
                tick();
                srst = 1'b1;
            end
        end
        for (int n = 0; n < 3; n++) send_word(DW'($urandom), 2);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
